// File: rtl/pkt_match_ctrl.sv
// Capture controller: config load, frame capture, FIFO drain, settle, priority match and record store.
// Outputs registered from next_state (no extra latency); no backpressure, the MAC/FIFO handshakes pace the FSM.
module pkt_match_ctrl #(
    parameter int N_CMP         = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_BEATS     = 1518,
    parameter int ADDR_W        = 8,
    parameter bit WRAP          = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          update_done,
    input  logic                                          ready,
    input  logic                                          eop,
    input  logic                                          error,
    input  logic                                          rdempty,
    input  logic [N_CMP-1:0]                              match,
    input  logic [N_CMP-1:0]                              match_mask,
    output logic                                          rdreq,
    output logic                                          cmp_en,
    output logic                                          cfg_sel,
    output logic                                          clear,
    output logic                                          mem_we,
    output logic [ADDR_W-1:0]                             mem_addr,
    output logic [((N_CMP > 1) ? $clog2(N_CMP) : 1)-1:0]  match_id,
    output logic                                          mem_full,
    output logic [CNT_W-1:0]                              frame_cnt,
    output logic [CNT_W-1:0]                              match_cnt,
    output logic [CNT_W-1:0]                              drop_cnt
);
    localparam int ID_W   = (N_CMP > 1) ? $clog2(N_CMP) : 1;
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        S_RESET, S_LOAD_CFG, S_IDLE, S_CAPTURE, S_DRAIN,
        S_SETTLE, S_DECIDE, S_STORE, S_ERROR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [3:0]        settle_cnt;
    logic [N_CMP-1:0]  masked;
    logic [ID_W-1:0]   winner;
    logic              permit;
    logic              timeout;
    logic              settle_done;

    assign masked      = match & match_mask;
    assign permit      = WRAP || !mem_full;
    assign timeout     = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign settle_done = (settle_cnt == 4'(SETTLE_CYCLES - 1));

    // Lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = N_CMP - 1; i >= 0; i--) begin
            if (masked[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_LOAD_CFG;
            S_LOAD_CFG: if (update_done) next_state = S_IDLE;
            S_IDLE:     if (ready) next_state = S_CAPTURE;
            S_CAPTURE: begin
                if (eop)                   next_state = S_DRAIN;
                else if (error || timeout) next_state = S_ERROR;
            end
            S_DRAIN:    if (rdempty) next_state = (SETTLE_CYCLES == 0) ? S_DECIDE : S_SETTLE;
            S_SETTLE:   if (settle_done) next_state = S_DECIDE;
            S_DECIDE:   next_state = (|masked && permit) ? S_STORE : S_IDLE;
            S_STORE:    next_state = S_IDLE;
            S_ERROR:    if (eop) next_state = S_IDLE;
            default:    next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RESET;
            cfg_sel    <= 1'b0;
            clear      <= 1'b0;
            rdreq      <= 1'b0;
            cmp_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            match_id   <= '0;
            mem_full   <= 1'b0;
            frame_cnt  <= '0;
            match_cnt  <= '0;
            drop_cnt   <= '0;
            beat_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            state   <= next_state;
            cfg_sel <= (next_state == S_LOAD_CFG);
            clear   <= (next_state == S_IDLE);
            rdreq   <= (next_state == S_CAPTURE);
            cmp_en  <= (next_state == S_DRAIN);
            mem_we  <= (next_state == S_STORE);

            // Both counters restart from zero every time their state is entered.
            beat_cnt   <= (state == S_CAPTURE) ? beat_cnt + BEAT_W'(1) : '0;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 4'd1 : 4'd0;

            if (next_state == S_STORE) match_id <= winner;

            if (state == S_STORE) begin
                if (mem_addr == ADDR_MAX) begin
                    mem_full <= 1'b1;
                    if (WRAP) mem_addr <= '0;
                end else begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
            end

            if (next_state == S_DECIDE && frame_cnt != CNT_MAX)
                frame_cnt <= frame_cnt + CNT_W'(1);
            if (next_state == S_STORE && match_cnt != CNT_MAX)
                match_cnt <= match_cnt + CNT_W'(1);
            if (((next_state == S_ERROR && state != S_ERROR) ||
                 (state == S_DECIDE && |masked && !permit)) && drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pkt_match_ctrl.sv
// Bench for pkt_match_ctrl: saturating and wrapping instances share stimulus; a monitor checks writes against a queue.
module tb_pkt_match_ctrl;
    localparam int S    = 4;
    localparam int MAXB = 24;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst, update_done, ready, eop, error, rdempty;
    logic [3:0] match, match_mask;

    logic       rdreq0, cmp_en0, cfg_sel0, clear0, we0, full0;
    logic [1:0] addr0, id0;
    logic [3:0] fc0, mc0, dc0;
    logic       rdreq1, cmp_en1, cfg_sel1, clear1, we1, full1;
    logic [1:0] addr1, id1;
    logic [3:0] fc1, mc1, dc1;

    pkt_match_ctrl #(.N_CMP(4), .SETTLE_CYCLES(S), .MAX_BEATS(MAXB), .ADDR_W(2), .WRAP(1'b0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .update_done(update_done), .ready(ready), .eop(eop), .error(error),
        .rdempty(rdempty), .match(match), .match_mask(match_mask), .rdreq(rdreq0), .cmp_en(cmp_en0),
        .cfg_sel(cfg_sel0), .clear(clear0), .mem_we(we0), .mem_addr(addr0), .match_id(id0),
        .mem_full(full0), .frame_cnt(fc0), .match_cnt(mc0), .drop_cnt(dc0));

    pkt_match_ctrl #(.N_CMP(4), .SETTLE_CYCLES(S), .MAX_BEATS(MAXB), .ADDR_W(2), .WRAP(1'b1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .update_done(update_done), .ready(ready), .eop(eop), .error(error),
        .rdempty(rdempty), .match(match), .match_mask(match_mask), .rdreq(rdreq1), .cmp_en(cmp_en1),
        .cfg_sel(cfg_sel1), .clear(clear1), .mem_we(we1), .mem_addr(addr1), .match_id(id1),
        .mem_full(full1), .frame_cnt(fc1), .match_cnt(mc1), .drop_cnt(dc1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int id; int cyc; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int m_addr[2], m_full[2], m_frame[2], m_match[2], m_drop[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int addr);
        checks++;
        errors++;
        $display("FAIL %s: unexpected write at addr %0d, expected none (cycle %0d)", name, addr, cyc);
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic logic any_out();
        return rdreq0 | cmp_en0 | cfg_sel0 | clear0 | we0 | full0 | (|addr0) | (|id0) | (|fc0) | (|mc0) | (|dc0) |
               rdreq1 | cmp_en1 | cfg_sel1 | clear1 | we1 | full1 | (|addr1) | (|id1) | (|fc1) | (|mc1) | (|dc1);
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int w = 0; w < 2; w++) begin
            m_addr[w] = 0; m_full[w] = 0; m_frame[w] = 0; m_match[w] = 0; m_drop[w] = 0;
        end
    endtask

    // Instance 0 saturates its address (WRAP=0), instance 1 wraps; memory has 4 entries.
    task automatic model_frame(input logic [3:0] m, input logic [3:0] k, input int rc);
        logic [3:0] masked;
        exp_t e;
        int id;
        masked = m & k;
        for (int w = 0; w < 2; w++) begin
            m_frame[w] = sat(m_frame[w]);
            if (masked != 4'd0) begin
                if (w == 1 || m_full[w] == 0) begin
                    id = 0;
                    while (!masked[id]) id++;
                    e.addr = m_addr[w]; e.id = id; e.cyc = rc + S + 2;
                    if (w == 0) q0.push_back(e); else q1.push_back(e);
                    m_match[w] = sat(m_match[w]);
                    if (m_addr[w] == 3) begin
                        m_full[w] = 1;
                        if (w == 1) m_addr[w] = 0;
                    end else begin
                        m_addr[w] = m_addr[w] + 1;
                    end
                end else begin
                    m_drop[w] = sat(m_drop[w]);
                end
            end
        end
    endtask

    task automatic check_state();
        check("frame_cnt0", int'(fc0), m_frame[0]);
        check("match_cnt0", int'(mc0), m_match[0]);
        check("drop_cnt0", int'(dc0), m_drop[0]);
        check("mem_full0", int'(full0), m_full[0]);
        check("mem_addr0", int'(addr0), m_addr[0]);
        check("frame_cnt1", int'(fc1), m_frame[1]);
        check("match_cnt1", int'(mc1), m_match[1]);
        check("drop_cnt1", int'(dc1), m_drop[1]);
        check("mem_full1", int'(full1), m_full[1]);
        check("mem_addr1", int'(addr1), m_addr[1]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (we0) begin
                if (q0.size() == 0) unexpected("write0", int'(addr0));
                else begin
                    e = q0.pop_front();
                    check("write0_addr", int'(addr0), e.addr);
                    check("write0_id", int'(id0), e.id);
                    check("write0_cycle", cyc, e.cyc);
                end
            end
            if (we1) begin
                if (q1.size() == 0) unexpected("write1", int'(addr1));
                else begin
                    e = q1.pop_front();
                    check("write1_addr", int'(addr1), e.addr);
                    check("write1_id", int'(id1), e.id);
                    check("write1_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_config();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("cfg_sel_high", int'(cfg_sel0 & cfg_sel1), 1);
            check("cfg_clear_low", int'(clear0 | clear1), 0);
            if (i == 3) update_done = 1'b1;
        end
        @(negedge clk);
        update_done = 1'b0;
        check("cfg_sel_low", int'(cfg_sel0 | cfg_sel1), 0);
        check("idle_clear", int'(clear0 & clear1), 1);
        check_state();
    endtask

    // kind: 0 normal, 1 error then eop 3 cycles later, 2 eop+error together, 3 timeout
    task automatic run_frame(input int kind, input int nb, input logic [3:0] m, input logic [3:0] k, input int dd);
        int rc, cnt;
        rc = 0;
        @(negedge clk);
        match = m; match_mask = k; rdempty = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        if (kind == 3) begin
            cnt = 0;
            while (rdreq0 && cnt < MAXB + 5) begin
                cnt++;
                @(negedge clk);
            end
            check("timeout_beats", cnt, MAXB);
            check("timeout_error_state", int'(clear0 | rdreq0 | clear1 | rdreq1), 0);
            eop = 1'b1;
            @(negedge clk);
            eop = 1'b0;
            check("timeout_exit", int'(clear0 & clear1), 1);
            for (int w = 0; w < 2; w++) m_drop[w] = sat(m_drop[w]);
        end else begin
            for (int i = 1; i <= nb; i++) begin
                check("capture_rdreq", int'(rdreq0 & rdreq1), 1);
                if (i == nb) begin
                    if (kind == 1) error = 1'b1;
                    else begin
                        eop = 1'b1;
                        error = (kind == 2);
                    end
                end
                @(negedge clk);
            end
            eop = 1'b0;
            error = 1'b0;
            if (kind == 1) begin
                for (int i = 1; i <= 3; i++) begin
                    check("error_hold", int'(clear0 | rdreq0 | cmp_en0 | clear1 | rdreq1 | cmp_en1), 0);
                    if (i == 3) eop = 1'b1;
                    @(negedge clk);
                end
                eop = 1'b0;
                check("error_exit", int'(clear0 & clear1), 1);
                for (int w = 0; w < 2; w++) m_drop[w] = sat(m_drop[w]);
            end else begin
                for (int i = 1; i <= dd; i++) begin
                    check("drain_cmp_en", int'(cmp_en0 & cmp_en1), 1);
                    if (i == dd) begin
                        rdempty = 1'b1;
                        rc = cyc;
                    end
                    @(negedge clk);
                end
                model_frame(m, k, rc);
                repeat (S + 3) @(negedge clk);
                check("frame_idle", int'(clear0 & clear1), 1);
            end
        end
        check_state();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int r, kind, nb;
        logic [3:0] m, k;
        rst = 1'b1; update_done = 1'b0; ready = 1'b0; eop = 1'b0; error = 1'b0;
        rdempty = 1'b1; match = 4'd0; match_mask = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", int'(any_out()), 0);
        rst = 1'b0;
        do_config();

        run_frame(0, 10, 4'b0110, 4'b1111, 5);
        run_frame(0, 6, 4'b0010, 4'b1101, 2);
        run_frame(1, 4, 4'b1111, 4'b1111, 1);
        run_frame(2, 3, 4'b0001, 4'b1111, 1);
        run_frame(0, MAXB, 4'b1000, 4'b1111, 3);
        run_frame(3, 0, 4'b1111, 4'b1111, 1);
        run_frame(0, 1, 4'b1111, 4'b1111, 1);
        run_frame(0, 5, 4'b0100, 4'b1111, 2);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : (r == 6) ? 2 : (r < 9) ? 1 : 3;
            nb = $urandom_range(1, MAXB);
            m = 4'($urandom_range(0, 15));
            k = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            run_frame(kind, nb, m, k, $urandom_range(1, 4));
        end

        // Reset while draining: outputs clear asynchronously, the frame leaves no trace.
        @(negedge clk);
        match = 4'b0001; match_mask = 4'hF; rdempty = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        check("pre_reset_drain", int'(cmp_en0 & cmp_en1), 1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", int'(any_out()), 0);
        model_reset();
        rdempty = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_config();
        run_frame(0, 7, 4'b1100, 4'b1111, 2);

        repeat (5) @(negedge clk);
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
